dmem_responder: RTL and testbench

//  Data-memory slave for the core's external data bus: services MREQ/WRITE/SIZE/DAD/DDT

---
 rtl/dmem_responder_pkg.sv | 57 +++++
 rtl/dmem_responder_ram.sv | 29 ++
 rtl/dmem_responder.sv | 143 ++++++++++++++
 tb/tb_dmem_responder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and lane-steering helpers for the dmem_responder data-memory slave.
// The optional misalignment trap is enabled by defining DMEM_MISALIGN_ERR_EN.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  typedef struct packed {
    logic        write;
    size_e       size;
    logic [31:0] addr;
  } req_t;

  // Byte enables for a right-justified access; half/word ignore the low address bits.
  function automatic logic [3:0] lane_enables(size_e size, logic [1:0] lane);
    case (size)
      SIZE_BYTE: return 4'b0001 << lane;
      SIZE_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(size_e size, logic [1:0] lane);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return lane[0];
      default:   return lane != 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] write_steer(size_e size, logic [31:0] data);
    case (size)
      SIZE_BYTE: return {4{data[7:0]}};
      SIZE_HALF: return {2{data[15:0]}};
      default:   return data;
    endcase
  endfunction

  function automatic logic [31:0] read_steer(size_e size, logic [1:0] lane, logic [31:0] word);
    case (size)
      SIZE_BYTE: return {24'h0, 8'(word >> {lane, 3'b000})};
      SIZE_HALF: return {16'h0, (lane[1] ? word[31:16] : word[15:0])};
      default:   return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_ram.sv
// Word-organised synchronous RAM with per-byte write enables and a registered read port.
module dmem_responder_ram #(
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];
  logic [31:0] rdata_q;

  // NOTE: the array has no reset so it maps onto block RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-bus slave: captures MREQ requests, waits WAIT_CYCLES, then pulses ACKD_n low.
// Define DMEM_MISALIGN_ERR_EN to trap misaligned half/word accesses via misalign_err.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MREQ,
  input  logic        WRITE,
  input  logic [1:0]  SIZE,
  input  logic [31:0] DAD,
  inout  wire  [31:0] DDT,
`ifdef DMEM_MISALIGN_ERR_EN
  output logic        misalign_err,
`endif
  output logic        ACKD_n
);

  localparam logic [3:0]  WAIT_LD  = 4'(WAIT_CYCLES);
  localparam logic [32:0] CAPACITY = 33'd4 << ADDR_WIDTH;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;

  req_t        cur_req;
  logic [31:0] cur_off;
  logic        cur_ok;
  logic        cur_mis;
  logic        ack_entry;
  logic        in_ack;

  logic                  ram_we;
  logic                  ram_re;
  logic [3:0]            ram_be;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_wdata;
  logic [31:0]           ram_rdata;

  logic        rd_drive;
  logic [31:0] rd_value;

  // In IDLE the live bus is decoded so a zero-wait access can commit on its capture edge.
  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    cur_req = req_q;
    if (state_q == ST_IDLE) begin
      cur_req.write = WRITE;
      cur_req.size  = size_e'(SIZE);
      cur_req.addr  = DAD;
    end
    cur_off = cur_req.addr - BASE_ADDR;
    cur_ok  = ({1'b0, cur_off} < CAPACITY);
`ifdef DMEM_MISALIGN_ERR_EN
    cur_mis = is_misaligned(cur_req.size, cur_req.addr[1:0]);
    cur_ok  = cur_ok && !cur_mis;
`else
    cur_mis = 1'b0;
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    ack_entry = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (MREQ) begin
          req_d = cur_req;
          cnt_d = WAIT_LD;
          if (WAIT_LD == 4'd0) begin
            state_d   = ST_ACK;
            ack_entry = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = ST_ACK;
          ack_entry = 1'b1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: flops take non-blocking assignments so every reader sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // The RAM access happens on the edge entering ACK; reset on that edge aborts it.
  always_comb begin
    ram_we    = ack_entry && cur_req.write && cur_ok && !rst;
    ram_re    = ack_entry && !cur_req.write && cur_ok && !rst;
    ram_be    = lane_enables(cur_req.size, cur_req.addr[1:0]);
    ram_addr  = cur_off[ADDR_WIDTH+1:2];
    ram_wdata = write_steer(cur_req.size, DDT);
  end

  dmem_responder_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    in_ack   = (state_q == ST_ACK);
    rd_drive = in_ack && !req_q.write;
    rd_value = cur_ok ? read_steer(req_q.size, req_q.addr[1:0], ram_rdata) : 32'h0;
  end

  assign ACKD_n = ~in_ack;
  assign DDT    = rd_drive ? rd_value : 'z;

`ifdef DMEM_MISALIGN_ERR_EN
  assign misalign_err = in_ack && cur_mis;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a byte-level memory model predicts every ACK and
// read value for two instances (WAIT_CYCLES=1 and WAIT_CYCLES=0), plus literal spot values.
module tb_dmem_responder;

  localparam int          NI       = 2;
  localparam logic [31:0] BASE     = 32'h0000_0000;
  localparam logic [31:0] IDLE_PAT = 32'hC3C3_3C3C;
  localparam logic [1:0]  SZ_B     = 2'b00;
  localparam logic [1:0]  SZ_H     = 2'b01;
  localparam logic [1:0]  SZ_W     = 2'b10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mreq   [NI];
  logic        wr     [NI];
  logic [1:0]  size   [NI];
  logic [31:0] dad    [NI];
  logic [31:0] drv    [NI];
  logic        drv_en [NI];
  wire         ackd_n_o [NI];
  wire  [31:0] ddt_o    [NI];
`ifdef DMEM_MISALIGN_ERR_EN
  wire         mis_o    [NI];
  logic        last_mis;
`endif

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int unsigned W = (g == 0) ? 1 : 0;

    wire [31:0] ddt;
    wire        ackd_n;
    assign ddt         = drv_en[g] ? drv[g] : 'z;
    assign ackd_n_o[g] = ackd_n;
    assign ddt_o[g]    = ddt;
`ifdef DMEM_MISALIGN_ERR_EN
    wire misalign_err;
    assign mis_o[g] = misalign_err;
`endif

    dmem_responder #(
      .ADDR_WIDTH  (14),
      .BASE_ADDR   (BASE),
      .WAIT_CYCLES (W)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .MREQ         (mreq[g]),
      .WRITE        (wr[g]),
      .SIZE         (size[g]),
      .DAD          (dad[g]),
      .DDT          (ddt),
`ifdef DMEM_MISALIGN_ERR_EN
      .misalign_err (misalign_err),
`endif
      .ACKD_n       (ackd_n)
    );

    // Model: a request is accepted once the slave is free, and answered W edges later.
    logic [7:0]  mem [int unsigned];
    int unsigned edge_n    = 0;
    int unsigned ack_edge  = 0;
    int unsigned free_edge = 0;
    bit          pend      = 0;
    bit          ack_now   = 0;
    bit          ack_read  = 0;
    bit          ack_mis   = 0;
    logic [31:0] ack_data  = '0;

    initial begin
      bit          t_wr;
      logic [1:0]  t_size;
      logic [31:0] t_addr;
      int unsigned n, off, start;
      bit          ok, mis;
      forever begin
        @(posedge clk);
        edge_n++;
        ack_now = 0;
        if (rst) begin
          pend      = 0;
          free_edge = edge_n + 1;
        end else begin
          if (!pend && mreq[g] && edge_n >= free_edge) begin
            pend     = 1;
            t_wr     = wr[g];
            t_size   = size[g];
            t_addr   = dad[g];
            ack_edge = edge_n + W;
          end
          if (pend && edge_n == ack_edge) begin
            pend      = 0;
            ack_now   = 1;
            free_edge = edge_n + 2;
            n   = (t_size == SZ_B) ? 1 : (t_size == SZ_H) ? 2 : 4;
            off = t_addr - BASE;
            ok  = off < 32'h0001_0000;
            mis = 0;
`ifdef DMEM_MISALIGN_ERR_EN
            mis = (t_addr % n) != 0;
            ok  = ok && !mis;
`endif
            start    = off - (off % n);
            ack_read = !t_wr;
            ack_mis  = mis;
            ack_data = '0;
            if (ok) begin
              for (int i = 0; i < int'(n); i++) begin
                if (t_wr) mem[start + i] = drv[g][8*i +: 8];
                else      ack_data |= 32'(mem[start + i]) << (8*i);
              end
            end
          end
        end
      end
    end

    initial begin
      forever begin
        @(negedge clk);
        if (edge_n >= 1) begin
          check($sformatf("ackd_n[%0d]", g), 32'(ackd_n), 32'(!ack_now));
          if (ack_now && ack_read)
            check($sformatf("read_data[%0d]", g), ddt, ack_data);
          else if (drv_en[g])
            check($sformatf("ddt_released[%0d]", g), ddt, drv[g]);
`ifdef DMEM_MISALIGN_ERR_EN
          check($sformatf("misalign_err[%0d]", g), 32'(misalign_err), 32'(ack_now && ack_mis));
`endif
        end
      end
    end
  end

  task automatic idle(input int g);
    mreq[g]   = 1'b0;
    wr[g]     = 1'b0;
    size[g]   = SZ_W;
    dad[g]    = '0;
    drv[g]    = IDLE_PAT;
    drv_en[g] = 1'b1;
  endtask

  task automatic drive_req(input int g, input bit w, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] d);
    mreq[g]   = 1'b1;
    wr[g]     = w;
    size[g]   = sz;
    dad[g]    = a;
    drv[g]    = w ? d : IDLE_PAT;
    drv_en[g] = w;
  endtask

  // Counts non-ACK cycles before the ACK pulse; a lost ACK is reported and abandoned.
  task automatic wait_ack(input int g, output logic [31:0] rd, output int lat);
    lat = 0;
    rd  = '0;
    forever begin
      @(negedge clk);
      if (ackd_n_o[g] == 1'b0) begin
        rd = ddt_o[g];
`ifdef DMEM_MISALIGN_ERR_EN
        last_mis = mis_o[g];
`endif
        break;
      end
      lat++;
      if (lat > 40) begin
        check("ack_timeout", 32'(lat), 32'd0);
        break;
      end
    end
  endtask

  task automatic xfer(input int g, input bit w, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rd, output int lat);
    drive_req(g, w, sz, a, d);
    wait_ack(g, rd, lat);
    @(posedge clk);
    #1 idle(g);
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    rst = 1'b1;
    for (int g = 0; g < NI; g++) idle(g);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Word write then read, one wait state.
    xfer(0, 1, SZ_W, 32'h100, 32'hDEAD_BEEF, rd, lat);
    check("wr_word_latency", 32'(lat), 32'd2);
    xfer(0, 0, SZ_W, 32'h100, '0, rd, lat);
    check("rd_word_latency", 32'(lat), 32'd2);
    check("rd_word_0x100", rd, 32'hDEAD_BEEF);

    // Reset in the middle of a write must abort it.
    xfer(0, 1, SZ_W, 32'h40, 32'h1234_5678, rd, lat);
    drive_req(0, 1, SZ_W, 32'h40, 32'hFFFF_0000);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(0);
    xfer(0, 0, SZ_W, 32'h40, '0, rd, lat);
    check("rd_after_reset_abort", rd, 32'h1234_5678);

    // Byte lanes, upper bus bits must be ignored on narrow writes.
    for (int i = 0; i < 4; i++)
      xfer(0, 1, SZ_B, 32'h200 + 32'(i), 32'hAABB_CC00 | 32'(8'h11 * (i + 1)), rd, lat);
    xfer(0, 0, SZ_W, 32'h200, '0, rd, lat);
    check("rd_word_0x200", rd, 32'h4433_2211);
    xfer(0, 0, SZ_H, 32'h202, '0, rd, lat);
    check("rd_half_0x202", rd, 32'h0000_4433);
    xfer(0, 0, SZ_B, 32'h201, '0, rd, lat);
    check("rd_byte_0x201", rd, 32'h0000_0022);

    // Out of range: reads zero, writes dropped, latency unchanged.
    xfer(0, 1, SZ_W, 32'h0, 32'h0BAD_F00D, rd, lat);
    xfer(0, 0, SZ_W, BASE + 32'h1_0000, '0, rd, lat);
    check("rd_oor_data", rd, 32'h0);
    check("rd_oor_latency", 32'(lat), 32'd2);
    xfer(0, 1, SZ_W, BASE + 32'h1_0000, 32'hFFFF_FFFF, rd, lat);
    xfer(0, 0, SZ_W, 32'hFFFF_FFFC, '0, rd, lat);
    check("rd_oor_wrap", rd, 32'h0);
    xfer(0, 0, SZ_W, 32'h0, '0, rd, lat);
    check("rd_word0_after_oor_wr", rd, 32'h0BAD_F00D);

    // Misaligned half writes.
    xfer(0, 1, SZ_W, 32'h300, 32'h0, rd, lat);
    xfer(0, 1, SZ_H, 32'h301, 32'h0000_ABCD, rd, lat);
`ifdef DMEM_MISALIGN_ERR_EN
    check("misalign_pulse", 32'(last_mis), 32'd1);
`endif
    xfer(0, 1, SZ_H, 32'h302, 32'h0000_1234, rd, lat);
    xfer(0, 0, SZ_W, 32'h300, '0, rd, lat);
`ifdef DMEM_MISALIGN_ERR_EN
    check("rd_word_0x300", rd, 32'h1234_0000);
    xfer(0, 0, SZ_W, 32'h302, '0, rd, lat);
    check("rd_misaligned_word", rd, 32'h0);
`else
    check("rd_word_0x300", rd, 32'h1234_ABCD);
`endif

    // Zero wait states: back-to-back reads with MREQ held, ACK every second cycle.
    for (int i = 0; i < 4; i++) begin
      xfer(1, 1, SZ_W, 32'h500 + 32'(4*i), 32'hC0DE_0000 + 32'(i), rd, lat);
      check("w0_wr_latency", 32'(lat), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      drive_req(1, 0, SZ_W, 32'h500 + 32'(4*i), '0);
      wait_ack(1, rd, lat);
      check($sformatf("w0_b2b_data_%0d", i), rd, 32'hC0DE_0000 + 32'(i));
      check($sformatf("w0_b2b_gap_%0d", i), 32'(lat), 32'd1);
      @(posedge clk);
      #1;
    end
    idle(1);

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
